// File: rtl/ottobit_pkg.sv
// ottobit_pkg: shared state encoding and sizing constants for the Ottobit datapath
package ottobit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult8_state_t;

    localparam int MULT8_ITERS  = 8;
    localparam int MULT8_PROD_W = 16;

endpackage

// File: rtl/adder8bit.sv
// adder8bit: 8-bit ripple-carry adder shared by the Ottobit datapath
module adder8bit (
    input  logic [7:0] In1,
    input  logic [7:0] In2,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);

    logic [8:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign Sum[i]   = In1[i] ^ In2[i] ^ c[i];
        assign c[i+1]   = (In1[i] & In2[i]) | (c[i] & (In1[i] ^ In2[i]));
    end

    assign Cout = c[8];

endmodule

// File: rtl/mult8_shift_add.sv
// mult8_shift_add: sequential 8x8->16 shift-and-add multiplier; MULT8_SIGNED_EN selects the two's-complement build
module mult8_shift_add
    import ottobit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              a,
    input  logic [7:0]              b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MULT8_PROD_W-1:0] product,
    output logic                    busy
);

    mult8_state_t state, state_nx;
    logic [7:0] mcand;
    logic [MULT8_PROD_W-1:0] p;
    logic [2:0] iter;
    logic [7:0] sum;
    logic cout;
    logic accept, last;
    logic [7:0] a_in, b_in;

`ifdef MULT8_SIGNED_EN
    localparam mult8_state_t AFTER_RUN = FIX;
    logic neg;
    assign a_in = a[7] ? -a : a;
    assign b_in = b[7] ? -b : b;
`else
    localparam mult8_state_t AFTER_RUN = DONE;
    assign a_in = a;
    assign b_in = b;
`endif

    assign accept    = in_valid && in_ready;
    assign last      = iter == 3'(MULT8_ITERS - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign product   = p;

    adder8bit u_add (
        .In1  (p[15:8]),
        .In2  (p[0] ? mcand : 8'h00),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: capture, iterate, optional sign fix-up, hold until consumed
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last ? AFTER_RUN : RUN;
            FIX:     state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: load operands on acceptance, then shift in one partial-product sum per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= 8'h00;
            p     <= '0;
            iter  <= 3'd0;
`ifdef MULT8_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else if (accept) begin
            mcand <= a_in;
            p     <= {8'h00, b_in};
            iter  <= 3'd0;
`ifdef MULT8_SIGNED_EN
            neg   <= a[7] ^ b[7];
`endif
        end else if (state == RUN) begin
            p    <= {cout, sum, p[7:1]};
            iter <= iter + 3'd1;
        end
`ifdef MULT8_SIGNED_EN
        else if (state == FIX) begin
            p <= neg ? -p : p;
        end
`endif
    end

endmodule
